// File: rtl/alu_iterative_exec_if.sv
// alu_iterative_exec_if
//   Start/Done handshake bundle between the datapath and the execute-stage ALU.
//   master : datapath side, drives the request and operands, receives results.
//   slave  : ALU side, samples the request and operands, drives results.
//   Signals:
//     Start        request, accepted only while Busy is low
//     ALUOperation 4-bit operation code from the ALU control decoder
//     A, B         operands
//     Shamt        shift amount (instruction bits [10:6])
//     Busy         operation in flight, including the Done cycle
//     Done         one-cycle pulse, results valid in this cycle
//     ALUResult    registered result
//     Zero         registered (ALUResult == 0)
//     BranchTaken  registered branch decision
interface alu_iterative_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Start;
  logic [3:0]            ALUOperation;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [4:0]            Shamt;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  Zero;
  logic                  BranchTaken;

  modport master (
    output Start, ALUOperation, A, B, Shamt,
    input  Busy, Done, ALUResult, Zero, BranchTaken
  );

  modport slave (
    input  Start, ALUOperation, A, B, Shamt,
    output Busy, Done, ALUResult, Zero, BranchTaken
  );
endinterface

// File: rtl/alu_iterative_exec.sv
// alu_iterative_exec
//   Execute-stage ALU with a Start/Done handshake. Logic, arithmetic, compare,
//   LUI and address operations complete in one cycle; SLL/SRL run through a
//   1-bit-per-cycle iterative shifter.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset (priority over Start)
//     bus    alu_iterative_exec_if slave modport (handshake, operands, results)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for Start; single-cycle ops computed on the accept edge
//   SHIFT | iterative shift in progress, one bit per cycle
//   DONE  | results valid, Done=1 and Busy=1 for exactly one cycle
module alu_iterative_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  alu_iterative_exec_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_NOR = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SUB = 4'd7;
  localparam logic [3:0] OP_BEQ = 4'd8;
  localparam logic [3:0] OP_BNE = 4'd9;
  localparam logic [3:0] OP_LUI = 4'd10;
  localparam logic [3:0] OP_LW  = 4'd11;
  localparam logic [3:0] OP_SW  = 4'd12;
  localparam logic [3:0] OP_JAL = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic                  branch_q;
  logic [DATA_WIDTH-1:0] work_q;
  logic [4:0]            cnt_q;
  logic                  dir_right_q;

  logic [DATA_WIDTH-1:0] single_res;
  logic                  single_bt;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  is_shift_op;

  assign is_shift_op = (bus.ALUOperation == OP_SLL) || (bus.ALUOperation == OP_SRL);

  // Results of every operation that finishes on the accept edge.
  // Codes 2, 13 and 14 fall into the default and produce zero.
  always_comb begin
    single_res = '0;
    single_bt  = 1'b0;
    case (bus.ALUOperation)
      OP_ADD: single_res = bus.A + bus.B;
      OP_AND: single_res = bus.A & bus.B;
      OP_NOR: single_res = ~(bus.A | bus.B);
      OP_OR:  single_res = bus.A | bus.B;
      OP_SUB: single_res = bus.A - bus.B;
      OP_BEQ: begin
        single_res = bus.A - bus.B;
        single_bt  = (bus.A == bus.B);
      end
      OP_BNE: begin
        single_res = bus.A - bus.B;
        single_bt  = (bus.A != bus.B);
      end
      // Low halfword moved into the upper half, lower half zero-filled.
      OP_LUI: single_res = bus.B << 16;
      OP_LW:  single_res = bus.A + bus.B;
      OP_SW:  single_res = bus.A + bus.B;
      OP_JAL: single_res = bus.A;
      default: single_res = '0;
    endcase
  end

  // One-bit step of the iterative shifter, direction latched at accept.
  always_comb begin
    shifted = work_q;
    if (dir_right_q) begin
      shifted = {1'b0, work_q[DATA_WIDTH-1:1]};
    end else begin
      shifted = {work_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      branch_q    <= 1'b0;
      work_q      <= '0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.Start) begin
            busy_q <= 1'b1;
            if (is_shift_op) begin
              if (bus.Shamt == 5'd0) begin
                // Zero-distance shift is a pass-through of B.
                result_q <= bus.B;
                zero_q   <= (bus.B == '0);
                branch_q <= 1'b0;
                done_q   <= 1'b1;
                state    <= DONE;
              end else begin
                work_q      <= bus.B;
                cnt_q       <= bus.Shamt;
                dir_right_q <= (bus.ALUOperation == OP_SRL);
                state       <= SHIFT;
              end
            end else begin
              result_q <= single_res;
              zero_q   <= (single_res == '0);
              branch_q <= single_bt;
              done_q   <= 1'b1;
              state    <= DONE;
            end
          end
        end

        SHIFT: begin
          work_q <= shifted;
          cnt_q  <= cnt_q - 5'd1;
          // Counter at 1 means this step is the last of the n shifts.
          if (cnt_q == 5'd1) begin
            result_q <= shifted;
            zero_q   <= (shifted == '0);
            branch_q <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.ALUResult   = result_q;
  assign bus.Zero        = zero_q;
  assign bus.BranchTaken = branch_q;

endmodule

// File: tb/tb_alu_iterative_exec.sv
// tb_alu_iterative_exec
//   Directed-vector bench for alu_iterative_exec with hand-computed results.
module tb_alu_iterative_exec;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_iterative_exec_if #(.DATA_WIDTH(32)) bus ();

  alu_iterative_exec #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, then scramble the inputs so any late sampling shows up.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input int exp_cyc,
                        input logic [31:0] exp_res, input logic exp_z, input logic exp_bt);
    int cyc;
    int busy_n;
    @(negedge clk);
    bus.ALUOperation = op;
    bus.A = a;
    bus.B = b;
    bus.Shamt = sh;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.A = ~a;
    bus.B = ~b;
    bus.Shamt = ~sh;
    bus.ALUOperation = ~op;
    cyc = 1;
    busy_n = bus.Busy ? 1 : 0;
    while (!bus.Done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.Busy) busy_n++;
    end
    check({tag, "_done"}, {31'd0, bus.Done}, 32'd1);
    check({tag, "_lat"}, cyc, exp_cyc);
    check({tag, "_busycyc"}, busy_n, exp_cyc);
    check({tag, "_res"}, bus.ALUResult, exp_res);
    check({tag, "_zero"}, {31'd0, bus.Zero}, {31'd0, exp_z});
    check({tag, "_bt"}, {31'd0, bus.BranchTaken}, {31'd0, exp_bt});
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, bus.Busy, bus.Done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int dones;
    int done_cyc;
    logic [31:0] done_res;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.Start = 1'b0;
    bus.ALUOperation = 4'd0;
    bus.A = '0;
    bus.B = '0;
    bus.Shamt = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_done", {31'd0, bus.Done}, 32'd0);
    check("rst_res", bus.ALUResult, 32'd0);
    check("rst_flags", {30'd0, bus.Zero, bus.BranchTaken}, 32'd0);
    reset = 1'b0;

    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 1, 32'h8000_0000, 1'b0, 1'b0);
    run_op("sub_eq", 4'd7, 32'd5, 32'd5, 5'd0, 1, 32'd0, 1'b1, 1'b0);
    run_op("beq", 4'd8, 32'd5, 32'd5, 5'd0, 1, 32'd0, 1'b1, 1'b1);
    run_op("bne", 4'd9, 32'd5, 32'd6, 5'd0, 1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op("beq_ne", 4'd8, 32'd5, 32'd6, 5'd0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("and", 4'd1, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd3, 1, 32'h00F0_F000, 1'b0, 1'b0);
    run_op("or", 4'd4, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 1, 32'hF0F0_0F0F, 1'b0, 1'b0);
    run_op("nor", 4'd3, 32'h0000_FFFF, 32'h00FF_0000, 5'd0, 1, 32'hFF00_0000, 1'b0, 1'b0);
    run_op("sll31", 4'd5, 32'hDEAD_BEEF, 32'h0000_0001, 5'd31, 32, 32'h8000_0000, 1'b0, 1'b0);
    run_op("srl4", 4'd6, 32'd0, 32'h8000_0000, 5'd4, 5, 32'h0800_0000, 1'b0, 1'b0);
    run_op("sll0", 4'd5, 32'd0, 32'h1234_5678, 5'd0, 1, 32'h1234_5678, 1'b0, 1'b0);
    run_op("srl1", 4'd6, 32'd0, 32'h0000_0003, 5'd1, 2, 32'h0000_0001, 1'b0, 1'b0);
    run_op("srl_out", 4'd6, 32'd0, 32'h0000_0001, 5'd1, 2, 32'h0000_0000, 1'b1, 1'b0);
    run_op("lui", 4'd10, 32'hFFFF_FFFF, 32'h0000_ABCD, 5'd0, 1, 32'hABCD_0000, 1'b0, 1'b0);
    run_op("jal", 4'd15, 32'h0040_0008, 32'h1111_1111, 5'd0, 1, 32'h0040_0008, 1'b0, 1'b0);
    run_op("lw", 4'd11, 32'd256, 32'hFFFF_FFFC, 5'd0, 1, 32'h0000_00FC, 1'b0, 1'b0);
    run_op("sw", 4'd12, 32'h1000_0000, 32'h0000_0010, 5'd0, 1, 32'h1000_0010, 1'b0, 1'b0);
    run_op("op13", 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1, 32'd0, 1'b1, 1'b0);
    run_op("op14", 4'd14, 32'h1234_0000, 32'h0000_5678, 5'd0, 1, 32'd0, 1'b1, 1'b0);
    run_op("op2", 4'd2, 32'h0000_0001, 32'h0000_0001, 5'd0, 1, 32'd0, 1'b1, 1'b0);

    // Starts during SHIFT and in the Done cycle must be ignored.
    @(negedge clk);
    bus.ALUOperation = 4'd6;
    bus.A = 32'd0;
    bus.B = 32'h8000_0000;
    bus.Shamt = 5'd4;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    dones = 0;
    done_cyc = 0;
    done_res = '0;
    for (cyc = 1; cyc <= 10; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (bus.Done) begin
        dones++;
        done_cyc = cyc;
        done_res = bus.ALUResult;
      end
      if (cyc == 2 || cyc == 5) begin
        bus.ALUOperation = (cyc == 2) ? 4'd0 : 4'd5;
        bus.A = 32'd1;
        bus.B = 32'h0000_0001;
        bus.Shamt = (cyc == 2) ? 5'd0 : 5'd2;
        bus.Start = 1'b1;
      end else begin
        bus.Start = 1'b0;
      end
    end
    check("ign_dones", dones, 1);
    check("ign_lat", done_cyc, 5);
    check("ign_res", done_res, 32'h0800_0000);
    check("ign_hold", bus.ALUResult, 32'h0800_0000);
    check("ign_idle", {30'd0, bus.Busy, bus.Done}, 32'd0);

    // Reset in cycle 3 of an SLL by 10 aborts it.
    @(negedge clk);
    bus.ALUOperation = 4'd5;
    bus.B = 32'h0000_0001;
    bus.Shamt = 5'd10;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    dones = 0;
    for (cyc = 1; cyc <= 3; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (bus.Done) dones++;
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {30'd0, bus.Busy, bus.Done}, 32'd0);
    check("rst_mid_res", bus.ALUResult, 32'd0);
    check("rst_mid_flags", {30'd0, bus.Zero, bus.BranchTaken}, 32'd0);
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.Done) dones++;
    end
    check("rst_mid_nodone", dones, 0);
    run_op("add_after_rst", 4'd0, 32'd2, 32'd3, 5'd0, 1, 32'd5, 1'b0, 1'b0);

    // Start held high: single-cycle ops re-accepted every other cycle.
    @(negedge clk);
    bus.ALUOperation = 4'd0;
    bus.A = 32'd10;
    bus.B = 32'd20;
    bus.Start = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.Done) dones++;
    end
    bus.Start = 1'b0;
    check("cont_dones", dones, 3);
    check("cont_res", bus.ALUResult, 32'd30);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
